// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bundle shared by fetch, data and memory sides.
// master drives req/wr/size/addr/wstrb/wdata; slave returns addr_ok/data_ok/rdata.
interface sram_like_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between fetch (inst) and data requesters.
// Ports: clk, reset (sync, active-high); inst/data slave bundles; mem master.
module sram_like_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  mem
);

    localparam int SW = $clog2(DATA_STREAK_MAX + 1);
    localparam logic [SW-1:0] S_MAX = SW'(DATA_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;

    logic              sel;
    logic              pick_data;
    logic              mem_req_c;
    logic              i_aok, d_aok, i_dok, d_dok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Data wins unless fetch is pending and data already had its full streak.
    assign pick_data = data.req && !(inst.req && (streak_q == S_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        mem_req_c = 1'b0;
        sel       = owner_q;
        i_aok     = 1'b0;
        d_aok     = 1'b0;
        i_dok     = 1'b0;
        d_dok     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inst.req || data.req) begin
                    sel       = pick_data;
                    mem_req_c = 1'b1;
                    owner_d   = pick_data;
                    // Streak only grows while fetch is actually waiting.
                    if (pick_data && inst.req) begin
                        if (streak_q != S_MAX)
                            streak_d = streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                    if (mem.addr_ok) begin
                        i_aok   = !pick_data;
                        d_aok   = pick_data;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                mem_req_c = 1'b1;
                if (mem.addr_ok) begin
                    i_aok   = !owner_q;
                    d_aok   = owner_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem.data_ok) begin
                    i_dok   = !owner_q;
                    d_dok   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs stay quiet during reset; buses fall back to fetch.
        if (reset) begin
            mem_req_c = 1'b0;
            sel       = 1'b0;
            i_aok     = 1'b0;
            d_aok     = 1'b0;
            i_dok     = 1'b0;
            d_dok     = 1'b0;
        end
    end

    assign sel_addr  = sel ? data.addr  : inst.addr;
    assign sel_wdata = sel ? data.wdata : inst.wdata;

    assign mem.req   = mem_req_c;
    assign mem.wr    = sel ? data.wr    : inst.wr;
    assign mem.size  = sel ? data.size  : inst.size;
    assign mem.wstrb = sel ? data.wstrb : inst.wstrb;
    assign mem.addr  = sel_addr;
    assign mem.wdata = sel_wdata;

    assign inst.addr_ok = i_aok;
    assign data.addr_ok = d_aok;
    assign inst.data_ok = i_dok;
    assign data.data_ok = d_dok;
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_sram_like_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    sram_like_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .DATA_STREAK_MAX(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if.slave),
        .data  (data_if.slave),
        .mem   (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_if.req   = 1'b0;
        inst_if.wr    = 1'b0;
        inst_if.size  = 2'd2;
        inst_if.addr  = 32'h0;
        inst_if.wstrb = 4'h0;
        inst_if.wdata = 32'h0;
        data_if.req   = 1'b0;
        data_if.wr    = 1'b0;
        data_if.size  = 2'd2;
        data_if.addr  = 32'h0;
        data_if.wstrb = 4'h0;
        data_if.wdata = 32'h0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b0;
        mem_if.rdata   = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inst_if.req  = 1'b1;
        inst_if.addr = 32'h0000_0100;
        data_if.req  = 1'b1;
        data_if.addr = 32'h0000_0200;
        mem_if.addr_ok = 1'b1;
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'h0000_1234;
        tick();
        @(negedge clk);
        total++;
        if (mem_if.req !== 1'b0) begin
            bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_if.req);
        end
        total++;
        if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b00) begin
            bad++; $display("FAIL rst_addr_ok got=%b%b exp=00",
                            inst_if.addr_ok, data_if.addr_ok);
        end
        total++;
        if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin
            bad++; $display("FAIL rst_data_ok got=%b%b exp=00",
                            inst_if.data_ok, data_if.data_ok);
        end
        total++;
        if (mem_if.addr !== 32'h0000_0100) begin
            bad++; $display("FAIL rst_mem_addr got=%h exp=00000100", mem_if.addr);
        end
        total++;
        if (inst_if.rdata !== 32'h0000_1234) begin
            bad++; $display("FAIL rst_rdata got=%h exp=00001234", inst_if.rdata);
        end
        total++;
        if (dut.state_q !== 2'd0 || dut.streak_q !== 3'd0) begin
            bad++; $display("FAIL rst_regs got=%0d/%0d exp=0/0",
                            dut.state_q, dut.streak_q);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_inst_only();
        inst_if.req  = 1'b1;
        inst_if.addr = 32'hBFC0_0000;
        mem_if.addr_ok = 1'b1;
        @(negedge clk);
        total++;
        if (inst_if.addr_ok !== 1'b1 || mem_if.req !== 1'b1) begin
            bad++; $display("FAIL io_grant got=%b%b exp=11",
                            inst_if.addr_ok, mem_if.req);
        end
        total++;
        if (mem_if.addr !== 32'hBFC0_0000) begin
            bad++; $display("FAIL io_mem_addr got=%h exp=bfc00000", mem_if.addr);
        end
        total++;
        if (data_if.addr_ok !== 1'b0) begin
            bad++; $display("FAIL io_data_aok got=%b exp=0", data_if.addr_ok);
        end
        tick();
        inst_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        @(negedge clk);
        total++;
        if (inst_if.data_ok !== 1'b0 || mem_if.req !== 1'b0) begin
            bad++; $display("FAIL io_wait got=%b%b exp=00",
                            inst_if.data_ok, mem_if.req);
        end
        tick();
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'h1C00_0000;
        @(negedge clk);
        total++;
        if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'h1C00_0000) begin
            bad++; $display("FAIL io_resp got=%b/%h exp=1/1c000000",
                            inst_if.data_ok, inst_if.rdata);
        end
        total++;
        if (data_if.data_ok !== 1'b0) begin
            bad++; $display("FAIL io_data_dok got=%b exp=0", data_if.data_ok);
        end
        tick();
        mem_if.data_ok = 1'b0;
        @(negedge clk);
        total++;
        if (dut.state_q !== 2'd0) begin
            bad++; $display("FAIL io_idle got=%0d exp=0", dut.state_q);
        end
        tick();
    endtask

    task automatic test_priority();
        inst_if.req   = 1'b1;
        inst_if.addr  = 32'h0000_0040;
        data_if.req   = 1'b1;
        data_if.wr    = 1'b1;
        data_if.addr  = 32'h0000_1004;
        data_if.wstrb = 4'hF;
        data_if.wdata = 32'hDEAD_BEEF;
        mem_if.addr_ok = 1'b1;
        @(negedge clk);
        total++;
        if (mem_if.wr !== 1'b1 || mem_if.addr !== 32'h0000_1004) begin
            bad++; $display("FAIL pr_mem_bus got=%b/%h exp=1/00001004",
                            mem_if.wr, mem_if.addr);
        end
        total++;
        if (mem_if.wdata !== 32'hDEAD_BEEF || mem_if.wstrb !== 4'hF) begin
            bad++; $display("FAIL pr_mem_wd got=%h/%h exp=deadbeef/f",
                            mem_if.wdata, mem_if.wstrb);
        end
        total++;
        if (data_if.addr_ok !== 1'b1 || inst_if.addr_ok !== 1'b0) begin
            bad++; $display("FAIL pr_grant got=%b%b exp=10",
                            data_if.addr_ok, inst_if.addr_ok);
        end
        tick();
        data_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        @(negedge clk);
        total++;
        if (inst_if.addr_ok !== 1'b0 || mem_if.req !== 1'b0) begin
            bad++; $display("FAIL pr_pending got=%b%b exp=00",
                            inst_if.addr_ok, mem_if.req);
        end
        tick();
        mem_if.data_ok = 1'b1;
        @(negedge clk);
        total++;
        if (data_if.data_ok !== 1'b1 || inst_if.data_ok !== 1'b0) begin
            bad++; $display("FAIL pr_resp got=%b%b exp=10",
                            data_if.data_ok, inst_if.data_ok);
        end
        tick();
        mem_if.data_ok = 1'b0;
        mem_if.addr_ok = 1'b1;
        @(negedge clk);
        total++;
        if (inst_if.addr_ok !== 1'b1 || mem_if.addr !== 32'h0000_0040) begin
            bad++; $display("FAIL pr_inst_next got=%b/%h exp=1/00000040",
                            inst_if.addr_ok, mem_if.addr);
        end
        tick();
        inst_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_streak();
        logic [5:0] exp_data;
        exp_data = 6'b10_1111;
        inst_if.req  = 1'b1;
        inst_if.addr = 32'h0000_0080;
        data_if.req  = 1'b1;
        data_if.addr = 32'h0000_2000;
        for (int t = 0; t < 6; t++) begin
            mem_if.addr_ok = 1'b1;
            mem_if.data_ok = 1'b0;
            @(negedge clk);
            total++;
            if (data_if.addr_ok !== exp_data[t] ||
                inst_if.addr_ok !== !exp_data[t]) begin
                bad++; $display("FAIL st_grant%0d got=d%b/i%b exp=d%b",
                                t, data_if.addr_ok, inst_if.addr_ok,
                                exp_data[t]);
            end
            tick();
            if (t == 4) begin
                total++;
                if (dut.streak_q !== 3'd0) begin
                    bad++; $display("FAIL st_clear got=%0d exp=0", dut.streak_q);
                end
            end
            mem_if.addr_ok = 1'b0;
            mem_if.data_ok = 1'b1;
            tick();
        end
        total++;
        if (dut.streak_q !== 3'd1) begin
            bad++; $display("FAIL st_final got=%0d exp=1", dut.streak_q);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_delayed_addr_ok();
        inst_if.req  = 1'b1;
        inst_if.addr = 32'h0000_2000;
        @(negedge clk);
        total++;
        if (mem_if.req !== 1'b1 || inst_if.addr_ok !== 1'b0) begin
            bad++; $display("FAIL da_issue got=%b%b exp=10",
                            mem_if.req, inst_if.addr_ok);
        end
        tick();
        data_if.req  = 1'b1;
        data_if.addr = 32'h0000_3000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (dut.state_q !== 2'd1 || mem_if.addr !== 32'h0000_2000 ||
                data_if.addr_ok !== 1'b0) begin
                bad++; $display("FAIL da_hold%0d got=%0d/%h/%b exp=1/00002000/0",
                                c, dut.state_q, mem_if.addr, data_if.addr_ok);
            end
            tick();
        end
        mem_if.addr_ok = 1'b1;
        @(negedge clk);
        total++;
        if (inst_if.addr_ok !== 1'b1 || data_if.addr_ok !== 1'b0 ||
            mem_if.addr !== 32'h0000_2000) begin
            bad++; $display("FAIL da_accept got=%b%b/%h exp=10/00002000",
                            inst_if.addr_ok, data_if.addr_ok, mem_if.addr);
        end
        tick();
        inst_if.req    = 1'b0;
        data_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1;
        @(negedge clk);
        total++;
        if (inst_if.data_ok !== 1'b1 || data_if.data_ok !== 1'b0) begin
            bad++; $display("FAIL da_resp got=%b%b exp=10",
                            inst_if.data_ok, data_if.data_ok);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious();
        mem_if.data_ok = 1'b1;
        @(negedge clk);
        total++;
        if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0 ||
            mem_if.req !== 1'b0) begin
            bad++; $display("FAIL sp_pulse got=%b%b%b exp=000",
                            inst_if.data_ok, data_if.data_ok, mem_if.req);
        end
        tick();
        mem_if.data_ok = 1'b0;
        @(negedge clk);
        total++;
        if (dut.state_q !== 2'd0) begin
            bad++; $display("FAIL sp_state got=%0d exp=0", dut.state_q);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        inst_if.req    = 1'b1;
        inst_if.addr   = 32'h0000_0500;
        mem_if.addr_ok = 1'b1;
        tick();
        inst_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        total++;
        if (dut.state_q !== 2'd2) begin
            bad++; $display("FAIL rm_in_resp got=%0d exp=2", dut.state_q);
        end
        tick();
        reset          = 1'b0;
        mem_if.data_ok = 1'b1;
        @(negedge clk);
        total++;
        if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0 ||
            dut.state_q !== 2'd0) begin
            bad++; $display("FAIL rm_late got=%b%b/%0d exp=00/0",
                            inst_if.data_ok, data_if.data_ok, dut.state_q);
        end
        tick();
        mem_if.data_ok = 1'b0;
        inst_if.req    = 1'b1;
        mem_if.addr_ok = 1'b1;
        @(negedge clk);
        total++;
        if (inst_if.addr_ok !== 1'b1 || mem_if.addr !== 32'h0000_0500) begin
            bad++; $display("FAIL rm_new_grant got=%b/%h exp=1/00000500",
                            inst_if.addr_ok, mem_if.addr);
        end
        tick();
        inst_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'hA5A5_0001;
        @(negedge clk);
        total++;
        if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'hA5A5_0001) begin
            bad++; $display("FAIL rm_new_resp got=%b/%h exp=1/a5a50001",
                            inst_if.data_ok, inst_if.rdata);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_inst_only();
        test_priority();
        test_streak();
        test_delayed_addr_ok();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
